mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage).
- Grants one access at a time and returns read data after a fixed memory latency.
- Generates the fetch and memory-stage stall signals that the hazard unit ORs into stallF and stallM.
- Sits between the mips core and a unified RAM that replaces separate imem/dmem.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_lat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding, latency
// counter width and the requester bundle used to mux the winning port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } arb_state_t;

    // Wide enough for MEM_LAT-1 with MEM_LAT in 1..4.
    localparam int LAT_W = 2;

    // Requester bundle widths; the top supports ADDR_W/DATA_W up to these.
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } arb_req_t;

    // Counter preload for a given read latency.
    function automatic logic [LAT_W-1:0] lat_preload(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter tracking the remaining cycles of an outstanding
// memory read. done is high whenever the count has reached zero.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [LAT_W-1:0] cnt;

    // Load on a read grant, otherwise count down while a read is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified RAM between instruction fetch (IF)
// and the MEM-stage data port. Data has priority; writes take one cycle and
// reads hold the memory for MEM_LAT cycles until rvalid.
// Optional: define MEM_ARB_STARVE_GUARD_EN to force an IF win after
// STARVE_MAX consecutive IDLE cycles in which IF lost to data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        state, state_nxt;
    arb_req_t          if_side, d_side, win;
    logic              if_win, d_win, starve_hit;
    logic              cnt_load, cnt_dec, cnt_done;
    logic              if_gnt_c, d_gnt_c, if_rv_c, d_rv_c;
    logic              mem_en_c, mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    // Bundle both requesters into the common request format.
    always_comb begin
        if_side       = '0;
        if_side.req   = if_req;
        if_side.addr  = REQ_ADDR_W'(if_addr);
        d_side        = '0;
        d_side.req    = d_req;
        d_side.we     = d_we;
        d_side.addr   = REQ_ADDR_W'(d_addr);
        d_side.wdata  = REQ_DATA_W'(d_wdata);
    end

    // Arbitration only happens in IDLE; data wins unless IF is starving.
    assign if_win = (state == IDLE) && if_side.req && (!d_side.req || starve_hit);
    assign d_win  = (state == IDLE) && d_side.req && !if_win;
    assign win    = if_win ? if_side : d_side;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign starve_hit = (starve_cnt == 3'(STARVE_MAX));

    // Count IF losses to data; any IF grant restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_win) begin
            starve_cnt <= '0;
        end else if (d_win && if_side.req) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    logic starve_unused;

    assign starve_hit    = 1'b0;
    assign starve_unused = (STARVE_MAX != 0);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    arb_lat_counter u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (lat_preload(MEM_LAT)),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Next state, grants, memory command and read completion.
    always_comb begin
        state_nxt   = state;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        if_rv_c     = 1'b0;
        d_rv_c      = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state)
            IDLE: begin
                if (if_win || d_win) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = win.we;
                    mem_addr_c  = ADDR_W'(win.addr);
                    mem_wdata_c = DATA_W'(win.wdata);
                end
                if (d_win) begin
                    d_gnt_c = 1'b1;
                    // Writes complete in the grant cycle; FSM stays in IDLE.
                    if (!d_side.we) begin
                        state_nxt = RD_D;
                        cnt_load  = 1'b1;
                    end
                end else if (if_win) begin
                    if_gnt_c  = 1'b1;
                    state_nxt = RD_IF;
                    cnt_load  = 1'b1;
                end
            end
            RD_IF: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    if_rv_c   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_D: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    d_rv_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture returned read data so rdata holds until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rv_c) if_rdata_q <= mem_rdata;
            if (d_rv_c)  d_rdata_q  <= mem_rdata;
        end
    end

    // Everything except the stalls is forced low while reset is asserted.
    assign if_gnt    = rst & if_gnt_c;
    assign d_gnt     = rst & d_gnt_c;
    assign if_rvalid = rst & if_rv_c;
    assign d_rvalid  = rst & d_rv_c;
    assign mem_en    = rst & mem_en_c;
    assign mem_we    = rst & mem_we_c;
    assign mem_addr  = rst ? mem_addr_c  : '0;
    assign mem_wdata = rst ? mem_wdata_c : '0;

    // The completing cycle presents memory data directly.
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;

    // Fetch stalls until granted or completing; writes stall until
    // granted, reads until their data returns.
    assign stall_if  = if_req & ~(if_gnt | if_rvalid);
    assign stall_mem = d_req & (d_we ? ~d_gnt : ~d_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int SMAX  = 4;
    localparam int LAT_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: MEM_LAT = 1
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // DUT B: MEM_LAT = 3
    logic        if_req_b = 0, d_req_b = 0, d_we_b = 0;
    logic [31:0] if_addr_b = 0, d_addr_b = 0, d_wdata_b = 0;
    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, stall_if_b, stall_mem_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .stall_if(stall_if_b), .stall_mem(stall_mem_b)
    );

    // Initial RAM contents, shared by the RAM models and the reference.
    function automatic logic [31:0] init_val(input logic [7:0] idx);
        if (idx == 8'h10) return 32'h8C01_0004;       // byte 0x40
        if (idx == 8'h40) return 32'hDEAD_BEEF;       // byte 0x100
        return {8'hC0, idx, ~idx, idx};
    endfunction

    // RAM model A: single port, read data one cycle after the command.
    logic [31:0] phys_a [256];
    bit          wr_a   [256];
    logic [31:0] pipe_a;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            phys_a[mem_addr[9:2]] <= mem_wdata;
            wr_a[mem_addr[9:2]]   <= 1'b1;
        end
        pipe_a <= (mem_en && !mem_we) ?
                  (wr_a[mem_addr[9:2]] ? phys_a[mem_addr[9:2]] : init_val(mem_addr[9:2])) : 32'hBAAD_F00D;
    end
    assign mem_rdata = pipe_a;

    // RAM model B: read-only, three-cycle latency.
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_b[0] <= (mem_en_b && !mem_we_b) ? init_val(mem_addr_b[9:2]) : 32'hBAAD_F00D;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rdata_b = pipe_b[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction-level view of the shared memory.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    int          m_busy;        // cycles left on the outstanding read
    bit          m_owner_d;
    logic [7:0]  m_idx;
    int          m_starve;
    logic [31:0] m_last_if, m_last_d;

    function automatic logic [31:0] ref_rd(input logic [7:0] idx);
        return ref_wr[idx] ? ref_mem[idx] : init_val(idx);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_starve = 0; m_last_if = 0; m_last_d = 0; m_owner_d = 0; m_idx = 0;
    endtask

    logic o_ig, o_dg, o_irv, o_drv, o_sif, o_sm, o_we;
    logic [31:0] o_addr, o_wd, o_ird, o_drd;

    // One clock of DUT A: compare against the model, then advance.
    task automatic step();
        logic e_ig, e_dg, e_irv, e_drv, e_en, e_we, i_win, dw;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        #1;
        e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_en = 0; e_we = 0;
        e_addr = 0; e_wd = 0; e_ird = m_last_if; e_drd = m_last_d;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_owner_d) begin e_drv = 1; e_drd = ref_rd(m_idx); m_last_d = e_drd; end
                else begin e_irv = 1; e_ird = ref_rd(m_idx); m_last_if = e_ird; end
            end
        end else begin
            i_win = if_req && (!d_req || (GUARD && m_starve == SMAX));
            dw    = d_req && !i_win;
            if (dw) begin
                e_dg = 1; e_en = 1; e_we = d_we; e_addr = d_addr;
                if (d_we) begin
                    e_wd = d_wdata; ref_mem[d_addr[9:2]] = d_wdata; ref_wr[d_addr[9:2]] = 1;
                end else begin
                    m_busy = LAT_A; m_owner_d = 1; m_idx = d_addr[9:2];
                end
                if (if_req) m_starve++;
            end else if (i_win) begin
                e_ig = 1; e_en = 1; e_addr = if_addr;
                m_busy = LAT_A; m_owner_d = 0; m_idx = if_addr[9:2]; m_starve = 0;
            end
        end
        chk("if_gnt", if_gnt, e_ig);
        chk("d_gnt", d_gnt, e_dg);
        chk("if_rvalid", if_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        chk("if_rdata", if_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        chk("stall_if", stall_if, if_req & ~(e_ig | e_irv));
        chk("stall_mem", stall_mem, d_req & (d_we ? ~e_dg : ~e_drv));
        o_ig = if_gnt; o_dg = d_gnt; o_irv = if_rvalid; o_drv = d_rvalid;
        o_sif = stall_if; o_sm = stall_mem; o_we = mem_we;
        o_addr = mem_addr; o_wd = mem_wdata; o_ird = if_rdata; o_drd = d_rdata;
        @(negedge clk);
    endtask

    // One clock with reset asserted: only the stalls may be nonzero.
    task automatic rst_check(input string tag);
        #1;
        chk({tag, "_if_gnt"}, if_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_if_rvalid"}, if_rvalid, 0);
        chk({tag, "_d_rvalid"}, d_rvalid, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_stall_if"}, stall_if, if_req);
        chk({tag, "_stall_mem"}, stall_mem, d_req);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        rst_check(tag);
        rst = 1;
        model_reset();
    endtask

    initial begin
        int sc, first, resume, g, rv, nb, ig;
        logic [31:0] rd_b;
        model_reset();
        o_ig = 0; o_dg = 0; o_irv = 0; o_drv = 0;
        @(negedge clk);

        // Reset with both requesters asking: no grants, stalls follow req.
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        rst_check("rst0");
        if_req = 0; d_req = 0;
        do_reset("rst1");

        // Three back-to-back writes while IF waits.
        if_req = 1; if_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            d_req = 1; d_we = 1; d_addr = 32'h10 + 32'(4 * k); d_wdata = 32'(k + 1);
            step();
            chk("wr_mem_we", o_we, 1);
            chk("wr_addr", o_addr, 32'h10 + 32'(4 * k));
            chk("wr_wdata", o_wd, 32'(k + 1));
            chk("wr_if_blocked", o_ig, 0);
            chk("wr_no_rvalid", o_irv | o_drv, 0);
        end
        d_req = 0; d_we = 0;

        // IF only, back-to-back fetches of 0x40.
        step(); chk("if0_gnt", o_ig, 1);
        step(); chk("if1_rvalid", o_irv, 1); chk("if1_rdata", o_ird, 32'h8C01_0004);
        step(); chk("if2_gnt", o_ig, 1);
        step(); chk("if3_rvalid", o_irv, 1);
        if_req = 0;
        step();

        // Collision: data read wins, IF follows after d_rvalid.
        sc = 0;
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
        step(); sc += int'(o_sif); chk("col0_dgnt", o_dg, 1); chk("col0_ifgnt", o_ig, 0);
        step(); sc += int'(o_sif); chk("col1_drvalid", o_drv, 1); chk("col1_drdata", o_drd, 32'hDEAD_BEEF);
        d_req = 0;
        step(); sc += int'(o_sif); chk("col2_ifgnt", o_ig, 1);
        step(); sc += int'(o_sif); chk("col3_ifrvalid", o_irv, 1);
        chk("col_stall_cycles", 32'(sc), 2);
        if_req = 0;
        step();

        // Reset while a data read is outstanding drops it.
        d_req = 1; d_we = 0; d_addr = 32'h14;
        step(); chk("rrd_gnt", o_dg, 1);
        do_reset("rrd");
        d_req = 0;
        step(); chk("rrd_no_rvalid", o_drv, 0);
        d_req = 1;
        step(); chk("rrd_regnt", o_dg, 1);
        step(); chk("rrd_rvalid", o_drv, 1); chk("rrd_rdata", o_drd, 32'h2);
        d_req = 0;
        step();

        // Continuous writes with IF pending: starvation behaviour.
        do_reset("stv");
        first = -1; resume = -1;
        if_req = 1; if_addr = 32'h48;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = $urandom;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_ig && first < 0) first = k;
            if (o_dg && first >= 0 && resume < 0) resume = k;
            if (o_irv) if_req = 0;
            if (o_dg) begin d_addr = 32'h20 + 32'(4 * ((k + 1) % 4)); d_wdata = $urandom; end
        end
        if (GUARD) begin
            chk("stv_first_ifgnt", 32'(first), 32'd4);
            chk("stv_data_resumes", 32'(resume), 32'd6);
        end else begin
            chk("stv_strict_priority", 32'(first), 32'hFFFF_FFFF);
        end
        if_req = 0; d_req = 0; d_we = 0;
        step(); step();

        // Randomized traffic under the protocol rules.
        for (int n = 0; n < 3000; n++) begin
            if (if_req && o_irv) if_req = 0;
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req  = 1;
                if_addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
            end
            if (d_req && (d_we ? o_dg : o_drv)) d_req = 0;
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 63)) << 2)
                          | 32'($urandom_range(0, 3));
                d_wdata = $urandom;
            end
            step();
        end
        if_req = 0; d_req = 0;

        // MEM_LAT = 3 instance: d read latency and quiet cycles.
        g = -1; rv = -1; nb = 0; ig = -1; rd_b = 0;
        if_req_b = 1; if_addr_b = 32'h40; d_req_b = 1; d_we_b = 0; d_addr_b = 32'h100;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (d_gnt_b && g < 0) g = c;
            if ((if_gnt_b || d_gnt_b) && g >= 0 && rv < 0 && c != g) nb++;
            if (d_rvalid_b && rv < 0) begin rv = c; rd_b = d_rdata_b; end
            if (if_gnt_b && ig < 0) ig = c;
            @(negedge clk);
            if (d_rvalid_b) d_req_b = 0;
            if (if_rvalid_b) if_req_b = 0;
        end
        chk("lat3_dgnt_cycle", 32'(g), 0);
        chk("lat3_rvalid_gap", 32'(rv - g), 3);
        chk("lat3_grants_between", 32'(nb), 0);
        chk("lat3_rdata", rd_b, 32'hDEAD_BEEF);
        chk("lat3_if_after", 32'(ig), 32'(rv + 1));
        if_req_b = 0; d_req_b = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
